spybuffer_reader: RTL
=====================

Name: spybuffer_reader

Overview:
- Consumes words from the read side of a SpyBuffer (first-word-fall-through disabled; 1-cycle read latency) and re-presents them on a valid/ready stream to downstream logic or a bench monitor.
- Counterpart to the SpyBuffer write-side drivers: it is the FIFO drain end.
- Tracks event framing through the metadata flag (word MSB), and keeps word and event counters plus a sticky framing-error flag.

Parameters:
- DATA_WIDTH, 65, full word width; bit DATA_WIDTH-1 is the metadata flag, bits DATA_WIDTH-2:0 are payload.
- CNT_WIDTH, 32, width of the status counters; counters saturate at all-ones.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new FIFO reads are issued; an in-flight read still completes.
- fifo_empty  in  1  SpyBuffer empty.
- fifo_read_data  in  DATA_WIDTH  SpyBuffer read_data; valid the cycle after fifo_read_enable.
- fifo_read_enable  out  1  SpyBuffer read_enable.
- out_data  out  DATA_WIDTH  downstream word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts when out_valid&&out_ready.
- word_count  out  CNT_WIDTH  words transferred downstream.
- event_count  out  CNT_WIDTH  complete events (footer accepted).
- in_event  out  1  high between accepted header and accepted footer.
- frame_error  out  1  sticky framing error.

Behaviour:
- Reset (async assert, sync release): fifo_read_enable=0, out_valid=0, out_data=0, word_count=0, event_count=0, in_event=0, frame_error=0. Skid buffer is emptied, the in-flight flag is cleared, and the FSM goes to IDLE. A reset during an in-flight read discards that word.
- Buffering:
  - 2-entry output skid buffer. occupancy = stored entries + in-flight read (0/1).
  - fifo_read_enable = enable && !fifo_empty && (occupancy < 2), evaluated against registered state. Combinational from fifo_empty/enable only; no path from out_ready.
  - The read word is captured into the skid buffer on the cycle after fifo_read_enable.
- Output:
  - out_data/out_valid are registered and driven from the head entry.
  - When out_valid is high and out_ready is low, out_data holds stable.
  - Minimum latency: fifo_read_enable at cycle N gives data at N+1 and out_valid at N+2.
  - Sustained throughput is 1 word/cycle with out_ready held high.
  - Ordering is strict FIFO; no word is dropped or duplicated.
- Framing FSM (advances only on downstream transfer, out_valid&&out_ready):
  - IDLE: meta=1 word is a header, go to IN_EVENT. meta=0 word sets frame_error, stay in IDLE.
  - IN_EVENT: meta=0 word is data, stay. meta=1 word is a footer: event_count++, go to IDLE.
  - in_event = (state==IN_EVENT).
  - Every transferred word is forwarded unmodified regardless of framing errors.
- Counters:
  - word_count increments on each transfer; event_count increments on each footer.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
- Boundary conditions:
  - fifo_empty rising while a read is in flight: the in-flight word is still captured.
  - Simultaneous capture and transfer with a full buffer is legal; occupancy stays constant.
  - enable deasserted mid-event: the FSM holds its state, and remaining buffered words drain to downstream.

Optional Feature:
- Macro SPYBUFFER_READER_STALL_CNT_EN.
- Defined: adds output stall_count [CNT_WIDTH].
  - Increments each cycle out_valid && !out_ready; saturating; reset to 0.
  - Also adds output starve_count [CNT_WIDTH], incremented each cycle enable && fifo_empty && in_event.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Basic event: FIFO preloaded with header 0x1_0000_0000_0000_00AA, data 0x0_..._0001, 0x0_..._0002, footer 0x1_..._00FF; out_ready=1. Required: 4 words out in order, back-to-back after the first, word_count=4, event_count=1, in_event=0, frame_error=0.
- Backpressure: same 4 words, out_ready toggling 1,0,0,1,... Required: out_data stable while stalled, fifo_read_enable never raised when occupancy=2, no loss or duplicates; with the macro defined, stall_count equals the number of stalled cycles.
- Framing error: first word 0x0_..._0005 while in IDLE. Required: word forwarded, frame_error=1 and remains 1 through a following valid event, event_count=1 after that event.
- Reset mid-flight: assert reset the cycle after fifo_read_enable. Required: all outputs 0 immediately (async); after release, the next read resumes from the FIFO's current head.
- enable gating: enable=0 with FIFO non-empty and 1 word buffered. Required: fifo_read_enable stays 0, the buffered word drains, in_event unchanged; enable=1 resumes reads the next cycle.
- Saturation (CNT_WIDTH=4): stream 20 data words inside one event. Required: word_count stops at 15, no wrap.

Source files
------------

// File: rtl/spybuffer_reader.sv
// spybuffer_reader: drains the read side of a SpyBuffer (1-cycle read latency,
// no first-word-fall-through) into a registered valid/ready output stream.
// It tracks header/footer event framing through the word MSB and keeps
// saturating word/event counters plus a sticky framing-error flag.
//
// Optional build macro: SPYBUFFER_READER_STALL_CNT_EN
//   When defined, adds stall_count (cycles with out_valid && !out_ready) and
//   starve_count (cycles with enable && fifo_empty && in_event).
//
// Handshake: a word moves downstream on every rising clock edge where
// out_valid && out_ready; out_valid never drops and out_data never changes
// while out_valid is high and out_ready is low.
module spybuffer_reader #(
    parameter int DATA_WIDTH = 65,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  event_count,
    output logic                  in_event,
    output logic                  frame_error
`ifdef SPYBUFFER_READER_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  starve_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_EVENT = 1'b1
    } state_t;

    state_t state, state_next;

    // Skid storage behind the output register; skid0 is the older entry.
    logic [DATA_WIDTH-1:0] skid0, skid1, skid0_next, skid1_next;
    logic [1:0]            skid_cnt, skid_cnt_next, fill;
    logic                  in_flight;
    logic [1:0]            occupancy;

    logic [DATA_WIDTH-1:0] out_data_next;
    logic                  out_valid_next;
    logic                  xfer, load_out, direct_load;
    logic                  meta;
    logic                  footer_seen, error_seen;

    // The output register is not counted in occupancy, so with out_ready held
    // high a read can be issued every cycle while the previous word is shown.
    assign occupancy = skid_cnt + {1'b0, in_flight};

    // Read issue depends only on registered state, enable and fifo_empty.
    assign fifo_read_enable = !reset && enable && !fifo_empty && (occupancy < 2'd2);

    assign xfer        = out_valid && out_ready;
    assign load_out    = !out_valid || xfer;
    assign direct_load = load_out && (skid_cnt == 2'd0) && in_flight;
    assign meta        = out_data[DATA_WIDTH-1];
    assign in_event    = (state == IN_EVENT);

    // Next contents of the output register and skid entries.
    always_comb begin
        out_valid_next = out_valid;
        out_data_next  = out_data;
        skid0_next     = skid0;
        skid1_next     = skid1;
        fill           = skid_cnt;
        if (load_out) begin
            if (skid_cnt != 2'd0) begin
                out_valid_next = 1'b1;
                out_data_next  = skid0;
                skid0_next     = skid1;
                fill           = skid_cnt - 2'd1;
            end else if (in_flight) begin
                out_valid_next = 1'b1;
                out_data_next  = fifo_read_data;
            end else begin
                out_valid_next = 1'b0;
            end
        end
        if (in_flight && !direct_load) begin
            if (fill == 2'd0) begin
                skid0_next = fifo_read_data;
            end else begin
                skid1_next = fifo_read_data;
            end
            fill = fill + 2'd1;
        end
        skid_cnt_next = fill;
    end

    // Buffer, output register and in-flight read tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid0     <= '0;
            skid1     <= '0;
            skid_cnt  <= 2'd0;
            in_flight <= 1'b0;
        end else begin
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            skid0     <= skid0_next;
            skid1     <= skid1_next;
            skid_cnt  <= skid_cnt_next;
            in_flight <= fifo_read_enable;
        end
    end

    // Framing next-state: advances only when a word is handed downstream.
    always_comb begin
        state_next  = state;
        footer_seen = 1'b0;
        error_seen  = 1'b0;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (meta) begin
                        state_next = IN_EVENT;
                    end else begin
                        error_seen = 1'b1;
                    end
                end
                IN_EVENT: begin
                    if (meta) begin
                        state_next  = IDLE;
                        footer_seen = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Framing state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Saturating word/event counters and sticky framing error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_count  <= '0;
            event_count <= '0;
            frame_error <= 1'b0;
        end else begin
            if (xfer && (word_count != CNT_MAX)) begin
                word_count <= word_count + 1'b1;
            end
            if (footer_seen && (event_count != CNT_MAX)) begin
                event_count <= event_count + 1'b1;
            end
            if (error_seen) begin
                frame_error <= 1'b1;
            end
        end
    end

`ifdef SPYBUFFER_READER_STALL_CNT_EN
    // Saturating downstream-stall and upstream-starvation counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count  <= '0;
            starve_count <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (enable && fifo_empty && in_event && (starve_count != CNT_MAX)) begin
                starve_count <= starve_count + 1'b1;
            end
        end
    end
`endif

endmodule
